// File: rtl/bram_wr_packer.sv
// Port-A write-side byte-lane packer: rotates four bytes per beat into a 32-bit BRAM word
// and issues a burst of consecutive writes. Optional per-byte mask: define PACKER_BYTE_MASK_EN.

`ifndef SELECT
`define SELECT 2
`endif

module bram_wr_packer #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 WR_EN,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      length,
  input  logic [`SELECT-1:0]   Sel,
  input  logic [7:0]           In1,
  input  logic [7:0]           In2,
  input  logic [7:0]           In3,
  input  logic [7:0]           In4,
`ifdef PACKER_BYTE_MASK_EN
  input  logic [3:0]           In_mask,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ADDR_W-1:0]    ADDR_A,
  output logic [31:0]          DIN_A,
  output logic [3:0]           WE_A,
  output logic                 EN_A,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
  logic [31:0]         din_q, din_d;
  logic [3:0]          we_q, we_d;
  logic                en_q, en_d;
  logic                done_q, done_d;

  logic [3:0]          beat_mask;
  logic [7:0]          beat [4];
  logic [31:0]         din_pack;
  logic [3:0]          we_pack;
  logic [1:0]          lane;
  logic                accept;

`ifdef PACKER_BYTE_MASK_EN
  assign beat_mask = In_mask;
`else
  assign beat_mask = 4'hF;
`endif

  assign beat[0] = In1;
  assign beat[1] = In2;
  assign beat[2] = In3;
  assign beat[3] = In4;

  // Logical byte i lands in lane (Sel + i) mod 4; mask bits follow their bytes.
  always_comb begin
    din_pack = '0;
    we_pack  = '0;
    lane     = '0;
    for (int i = 0; i < 4; i++) begin
      lane                = 2'(Sel) + 2'(i);
      din_pack[8*lane +: 8] = beat[i];
      we_pack[lane]       = beat_mask[i];
    end
  end

  assign in_ready = (state_q == StRun) && WR_EN;
  assign accept   = in_ready && in_valid;
  assign busy     = (state_q != StIdle);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    addr_a_d = addr_a_q;
    din_d    = din_q;
    we_d     = '0;
    en_d     = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = base_addr;
            rem_d   = length;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (accept) begin
          en_d     = 1'b1;
          we_d     = we_pack;
          din_d    = din_pack;
          addr_a_d = addr_q;
          addr_d   = addr_q + 1'b1;
          rem_d    = rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      rem_q    <= '0;
      addr_a_q <= '0;
      din_q    <= '0;
      we_q     <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      addr_a_q <= addr_a_d;
      din_q    <= din_d;
      we_q     <= we_d;
      en_q     <= en_d;
      done_q   <= done_d;
    end
  end

  assign ADDR_A = addr_a_q;
  assign DIN_A  = din_q;
  assign WE_A   = we_q;
  assign EN_A   = en_q;
  assign done   = done_q;

endmodule

// File: tb/tb_bram_wr_packer.sv
// Self-checking bench for bram_wr_packer: directed bursts plus randomized beats against a
// transaction-level model of the expected port-A write sequence.

module tb_bram_wr_packer;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [1:0]    sel = '0;
  logic [7:0]    in1 = '0, in2 = '0, in3 = '0, in4 = '0;
  logic [3:0]    in_mask = 4'hF;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] addr_a;
  logic [31:0]   din_a;
  logic [3:0]    we_a;
  logic          en_a, busy, done;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] last_addr = '0;
  logic [31:0]   last_din = '0;

  bram_wr_packer #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .WR_EN(wr_en), .start(start), .base_addr(base_addr),
    .length(length), .Sel(sel), .In1(in1), .In2(in2), .In3(in3), .In4(in4),
`ifdef PACKER_BYTE_MASK_EN
    .In_mask(in_mask),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .ADDR_A(addr_a), .DIN_A(din_a), .WE_A(we_a),
    .EN_A(en_a), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: byte i goes to lane (sel+i)%4, computed as plain arithmetic.
  function automatic logic [31:0] model_word(input logic [7:0] b1, input logic [7:0] b2,
                                             input logic [7:0] b3, input logic [7:0] b4,
                                             input logic [1:0] s);
    logic [31:0] w;
    int          bytes [4];
    bytes = '{int'(b1), int'(b2), int'(b3), int'(b4)};
    w = 0;
    for (int i = 0; i < 4; i++) w = w | (32'(bytes[i]) << (8 * ((int'(s) + i) % 4)));
    return w;
  endfunction

  function automatic logic [3:0] model_we(input logic [3:0] m, input logic [1:0] s);
`ifdef PACKER_BYTE_MASK_EN
    logic [3:0] r;
    r = 0;
    for (int i = 0; i < 4; i++) if (m[i]) r = r | (4'(1) << ((int'(s) + i) % 4));
    return r;
`else
    return (m == m) ? 4'hF : 4'hF;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_addr"}, addr_a, 0);
    chk({tag, "_din"}, din_a, 0);
    chk({tag, "_we"}, we_a, 0);
    chk({tag, "_en"}, en_a, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // mode 0: random handshake/data; 1: rotation sweep; 2: 3-cycle WR_EN stall after first
  // beat; 3: start pulsed during the burst; 4: directed mask beats.
  task automatic run_burst(input logic [AW-1:0] base, input logic [AW:0] len, input int mode);
    int            n = 0;
    int            cyc = 0;
    int            stall = 0;
    int            limit;
    logic          acc;
    logic          need_beat = 1'b1;
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    logic [3:0]    ew;
    limit = 4 * int'(len) + 20;
    base_addr = base;
    length = len;
    in_valid = 1'b0;
    start = 1'b1;
    #1;
    chk("idle_ready", in_ready, 0);
    tick();
    start = 1'b0;
    chk("start_busy", busy, len != 0);
    chk("start_en", en_a, 0);
    chk("start_done", done, len == 0);
    if (len == 0) begin
      tick();
      chk("zl_busy", busy, 0);
      chk("zl_done", done, 0);
      chk("zl_en", en_a, 0);
      return;
    end
    while (n < int'(len) && cyc < limit) begin
      if (need_beat) begin
        {in1, in2, in3, in4} = $urandom;
        sel = 2'($urandom_range(0, 3));
        in_mask = 4'($urandom_range(0, 15));
        need_beat = 1'b0;
      end
      start = 1'b0;
      case (mode)
        1: begin
          wr_en = 1'b1; in_valid = 1'b1;
          {in1, in2, in3, in4} = 32'h11223344;
          sel = 2'(n);
          in_mask = 4'hF;
        end
        2: begin
          wr_en = (stall == 0); in_valid = 1'b1;
        end
        3: begin
          wr_en = 1'b1; in_valid = 1'b1;
          if (cyc == 1) begin
            start = 1'b1; base_addr = base + 10'h100; length = 11'd7;
          end
        end
        4: begin
          wr_en = 1'b1; in_valid = 1'b1;
          sel = 2'd3;
          in_mask = (n == 0) ? 4'b0011 : 4'b0000;
        end
        default: begin
          wr_en = ($urandom_range(0, 3) != 0);
          in_valid = ($urandom_range(0, 3) != 0);
        end
      endcase
      #1;
      chk("run_ready", in_ready, wr_en);
      acc = wr_en && in_valid;
      ea = base + AW'(n);
      ed = model_word(in1, in2, in3, in4, sel);
      ew = model_we(in_mask, sel);
      tick();
      cyc++;
      if (stall > 0) stall--;
      chk("run_en", en_a, acc);
      chk("run_done", done, acc && (n == int'(len) - 1));
      chk("run_busy", busy, 1);
      if (acc) begin
        chk("wr_addr", addr_a, ea);
        chk("wr_din", din_a, ed);
        chk("wr_we", we_a, ew);
        last_addr = ea;
        last_din = ed;
        n++;
        need_beat = 1'b1;
        if (mode == 2 && n == 1) stall = 3;
      end else begin
        chk("hold_addr", addr_a, last_addr);
        chk("hold_din", din_a, last_din);
        chk("idle_we", we_a, 0);
      end
    end
    if (cyc >= limit) chk("burst_timeout", 1, 0);
    // Now in the DONE cycle: no beats may be accepted, then back to IDLE.
    start = 1'b0;
    wr_en = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("done_ready", in_ready, 0);
    tick();
    chk("post_busy", busy, 0);
    chk("post_en", en_a, 0);
    chk("post_done", done, 0);
    chk("post_ready", in_ready, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    wr_en = 1'b1;
    tick();

    run_burst(10'h000, 11'd4, 1);       // rotation sweep
    run_burst(10'h3FE, 11'd4, 0);       // wrap-around
    run_burst(10'h123, 11'd2, 2);       // stall
    run_burst(10'h055, 11'd0, 0);       // zero length
    run_burst(10'h200, 11'd3, 3);       // ignored restart
    run_burst(10'h0A0, 11'd2, 4);       // mask beats

    // Reset mid-burst.
    base_addr = 10'h010; length = 11'd3; start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b1; in_valid = 1'b1;
    {in1, in2, in3, in4} = 32'hA1B2C3D4; sel = 2'd0;
    tick();
    chk("pre_rst_en", en_a, 1);
    chk("pre_rst_addr", addr_a, 10'h010);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_idle_done", done, 0);
    tick();
    chk("rst_after_busy", busy, 0);
    chk("rst_after_done", done, 0);
    last_addr = '0;
    last_din = '0;
    run_burst(10'h010, 11'd3, 0);

    for (int k = 0; k < 8; k++) begin
      run_burst(AW'($urandom), 11'($urandom_range(1, 40)), 0);
    end
    run_burst(10'h2C7, 11'd1024, 0);    // full-memory burst

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
